// File: rtl/jesd_tx_pkg.sv
// Shared constants and types for the JESD204B transmit lane controller.
// Control characters, link-state encoding and the per-clock output word.
package jesd_tx_pkg;

    localparam int DATA_W = 32;
    localparam int OCTETS = DATA_W / 8;

    localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code-group sync
    localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
    localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
    localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config data follows

    localparam logic [1:0] ST_CGS       = 2'd0;
    localparam logic [1:0] ST_WAIT_LMFC = 2'd1;
    localparam logic [1:0] ST_ILAS      = 2'd2;
    localparam logic [1:0] ST_DATA      = 2'd3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [OCTETS-1:0] charisk;
    } tx_word_t;

    function automatic tx_word_t cgs_word();
        tx_word_t w;
        w.data    = {OCTETS{K28_5}};
        w.charisk = '1;
        return w;
    endfunction

endpackage

// File: rtl/jesd_tx_scrambler.sv
// Self-synchronous 1+x^14+x^15 scrambler, 32 bits per clock, octet 0 first, MSB first.
// Compiled only when SCRAMBLER_EN is defined; the default build has no scrambler at all.
`ifdef SCRAMBLER_EN
module jesd_tx_scrambler
    import jesd_tx_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam logic [14:0] SEED = 15'h7FFF;

    // st[0] holds the most recent scrambled bit, st[14] the oldest.
    function automatic logic [14+DATA_W:0] scramble(input logic [14:0] st_in,
                                                   input logic [DATA_W-1:0] d);
        logic [14:0]       st;
        logic [DATA_W-1:0] q;
        logic              b;
        logic [4:0]        pos;
        st = st_in;
        q  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pos    = 5'((i / 8) * 8 + 7 - (i % 8));
            b      = d[pos] ^ st[13] ^ st[14];
            q[pos] = b;
            st     = {st[13:0], b};
        end
        return {st, q};
    endfunction

    logic [14:0] lfsr;
    logic [14:0] lfsr_cur;
    logic [14:0] lfsr_nxt;

    always_comb begin
        lfsr_cur             = load ? SEED : lfsr;
        {lfsr_nxt, data_out} = scramble(lfsr_cur, data_in);
    end

    // ---- stage p1: scrambler history ----
    always_ff @(posedge clk) begin
        if (enable) begin
            lfsr <= lfsr_nxt;
        end
    end

endmodule
`endif

// File: rtl/jesd_tx_lane_ctrl.sv
// JESD204B transmit-lane link controller: CGS, LMFC-aligned ILAS, then user data.
// Define SCRAMBLER_EN to scramble DATA-state octets (1+x^14+x^15); otherwise data passes through.
module jesd_tx_lane_ctrl
    import jesd_tx_pkg::*;
#(
    parameter int MF_CLKS = 8,
    parameter int ILAS_MF = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sysref,
    input  logic              sync_n,
    input  logic [111:0]      cfg_octets,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic [OCTETS-1:0] tx_charisk,
    output logic [1:0]        link_state,
    output logic              lmfc_valid,
    output logic              sysref_misalign
);

    localparam logic [5:0] WORD_LAST = 6'(MF_CLKS - 1);
    localparam logic [2:0] MF_LAST   = 3'(ILAS_MF - 1);
    localparam logic [7:0] IDX_LAST  = 8'(4 * MF_CLKS - 1);

    logic              sysref_q;
    logic              sysref_edge;
    logic [5:0]        lmfc_cnt;
    logic              sync_p0;
    logic              sync_p1;
    logic              sync_p2;
    logic              sync_drop;
    logic [1:0]        state_nxt;
    logic [5:0]        ilas_word;
    logic [5:0]        ilas_word_nxt;
    logic [2:0]        ilas_mf;
    logic [2:0]        ilas_mf_nxt;
    logic [DATA_W-1:0] data_path;
    tx_word_t          word_nxt;

    // One ILAS word: octet ramp framed by /R/ and /A/, config block in the second multiframe.
    function automatic tx_word_t ilas_word_f(input logic [5:0] word, input logic [2:0] mf,
                                            input logic [111:0] cfg);
        tx_word_t   w;
        logic [7:0] idx;
        logic [6:0] base;
        w = '0;
        for (int k = 0; k < OCTETS; k++) begin
            idx  = {word, k[1:0]};
            base = {idx[3:0] - 4'd2, 3'b000};
            w.data[8*k +: 8] = idx;
            w.charisk[k]     = 1'b0;
            if (idx == 8'd0) begin
                w.data[8*k +: 8] = K28_0;
                w.charisk[k]     = 1'b1;
            end else if (idx == IDX_LAST) begin
                w.data[8*k +: 8] = K28_3;
                w.charisk[k]     = 1'b1;
            end else if (mf == 3'd1 && idx == 8'd1) begin
                w.data[8*k +: 8] = K28_4;
                w.charisk[k]     = 1'b1;
            end else if (mf == 3'd1 && idx <= 8'd15) begin
                w.data[8*k +: 8] = cfg[base +: 8];
            end
        end
        return w;
    endfunction

    assign sysref_edge = sysref & ~sysref_q;

    // ---- stage p1: SYSREF edge detect and LMFC phase ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sysref_q        <= 1'b0;
            lmfc_cnt        <= '0;
            lmfc_valid      <= 1'b0;
            sysref_misalign <= 1'b0;
        end else begin
            sysref_q        <= sysref;
            sysref_misalign <= sysref_edge & lmfc_valid & (lmfc_cnt != WORD_LAST);
            lmfc_valid      <= lmfc_valid | sysref_edge;
            if (sysref_edge || lmfc_cnt == WORD_LAST) begin
                lmfc_cnt <= '0;
            end else begin
                lmfc_cnt <= lmfc_cnt + 6'd1;
            end
        end
    end

    // ---- stage p0..p2: SYNC~ synchronizer plus one extra tap for glitch rejection ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= sync_n;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign sync_drop = ~sync_p1 & ~sync_p2;

    always_comb begin
        state_nxt = link_state;
        if (link_state == ST_ILAS && ilas_word == WORD_LAST) begin
            ilas_word_nxt = '0;
            ilas_mf_nxt   = ilas_mf + 3'd1;
        end else begin
            ilas_word_nxt = ilas_word + 6'd1;
            ilas_mf_nxt   = ilas_mf;
        end
        case (link_state)
            ST_CGS: begin
                if (sync_p1 && lmfc_valid) begin
                    state_nxt = ST_WAIT_LMFC;
                end
            end
            ST_WAIT_LMFC: begin
                // Leave on the last LMFC clock so ILAS word 0 lands on lmfc_cnt 0.
                if (lmfc_cnt == WORD_LAST) begin
                    state_nxt     = ST_ILAS;
                    ilas_word_nxt = '0;
                    ilas_mf_nxt   = '0;
                end
            end
            ST_ILAS: begin
                if (ilas_word == WORD_LAST && ilas_mf == MF_LAST) begin
                    state_nxt = ST_DATA;
                end
            end
            default: ;
        endcase
        if (link_state != ST_CGS && sync_drop) begin
            state_nxt = ST_CGS;
        end
    end

`ifdef SCRAMBLER_EN
    logic [DATA_W-1:0] scr_data;

    jesd_tx_scrambler u_scrambler (
        .clk      (clk),
        .load     (link_state != ST_DATA),
        .enable   (state_nxt == ST_DATA),
        .data_in  (data_in),
        .data_out (scr_data)
    );

    assign data_path = scr_data;
`else
    assign data_path = data_in;
`endif

    // Output word is selected from the next state so every output is registered.
    always_comb begin
        word_nxt = cgs_word();
        case (state_nxt)
            ST_ILAS: word_nxt = ilas_word_f(ilas_word_nxt, ilas_mf_nxt, cfg_octets);
            ST_DATA: begin
                word_nxt.data    = data_path;
                word_nxt.charisk = '0;
            end
            default: ;
        endcase
    end

    // ---- stage p1: link state and output registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_state <= ST_CGS;
            ilas_word  <= '0;
            ilas_mf    <= '0;
            data_ready <= 1'b0;
            tx_data    <= '0;
            tx_charisk <= '0;
        end else begin
            link_state <= state_nxt;
            ilas_word  <= ilas_word_nxt;
            ilas_mf    <= ilas_mf_nxt;
            data_ready <= (state_nxt == ST_DATA);
            tx_data    <= word_nxt.data;
            tx_charisk <= word_nxt.charisk;
        end
    end

endmodule

// File: tb/tb_jesd_tx_lane_ctrl.sv
// Bench for jesd_tx_lane_ctrl: directed ILAS/link vectors plus randomized traffic
// checked every cycle against a history-based reference model.
module tb_jesd_tx_lane_ctrl;

    localparam int MF   = 8;
    localparam int IMF  = 4;
    localparam int HMAX = 2048;

    logic         clk = 1'b0;
    logic         reset;
    logic         sysref;
    logic         sync_n;
    logic [111:0] cfg_octets;
    logic [31:0]  data_in;
    logic         data_ready;
    logic [31:0]  tx_data;
    logic [3:0]   tx_charisk;
    logic [1:0]   link_state;
    logic         lmfc_valid;
    logic         sysref_misalign;

    int errors = 0;
    int checks = 0;

    jesd_tx_lane_ctrl #(.MF_CLKS(MF), .ILAS_MF(IMF)) dut (
        .clk             (clk),
        .reset           (reset),
        .sysref          (sysref),
        .sync_n          (sync_n),
        .cfg_octets      (cfg_octets),
        .data_in         (data_in),
        .data_ready      (data_ready),
        .tx_data         (tx_data),
        .tx_charisk      (tx_charisk),
        .link_state      (link_state),
        .lmfc_valid      (lmfc_valid),
        .sysref_misalign (sysref_misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  k;
        logic [1:0]  st;
        logic        rdy;
        logic        vld;
        logic        mis;
    } obs_t;

    typedef struct {
        int          off;
        logic [31:0] data;
        logic [3:0]  k;
    } ilas_vec_t;

    // ---------------- reference model state (input history per cycle) ----------------
    logic        sr_h  [HMAX];
    logic        sn_h  [HMAX];
    logic [31:0] din_h [HMAX];
    logic [7:0]  cfg_b [14];
    int          cyc;
    int          m_state;
    int          m_ilas_start;
    int          m_last_edge;
    bit          m_valid;
    obs_t        m_exp;

    function automatic bit sync_s_at(int c);
        return (c >= 2) ? bit'(sn_h[c-2]) : 1'b0;
    endfunction

    // LMFC phase: clocks elapsed since the clock after the last SYSREF edge (or since reset).
    function automatic int lmfc_at(int c);
        return (c - m_last_edge - 1) % MF;
    endfunction

    function automatic logic [35:0] ilas_exp(int n);
        logic [31:0] d;
        logic [3:0]  k;
        int          mf;
        int          idx;
        mf = n / MF;
        for (int o = 0; o < 4; o++) begin
            idx = 4 * (n % MF) + o;
            d[8*o +: 8] = 8'(idx);
            k[o] = 1'b0;
            if (idx == 0) begin
                d[8*o +: 8] = 8'h1C;
                k[o] = 1'b1;
            end else if (idx == 4 * MF - 1) begin
                d[8*o +: 8] = 8'h7C;
                k[o] = 1'b1;
            end else if (mf == 1 && idx == 1) begin
                d[8*o +: 8] = 8'h9C;
                k[o] = 1'b1;
            end else if (mf == 1 && idx >= 2 && idx <= 15) begin
                d[8*o +: 8] = cfg_b[idx-2];
            end
        end
        return {d, k};
    endfunction

    task automatic model_step();
        int c;
        bit e;
        bit ss;
        bit drop;
        int lm;
        int nst;
        c    = cyc;
        e    = sr_h[c] && (c == 0 || !sr_h[c-1]);
        ss   = sync_s_at(c);
        drop = !ss && !sync_s_at(c - 1);
        lm   = lmfc_at(c);
        nst  = m_state;
        case (m_state)
            0: if (ss && m_valid) nst = 1;
            1: if (lm == MF - 1) begin
                nst = 2;
                m_ilas_start = c + 1;
            end
            2: if (c - m_ilas_start == IMF * MF - 1) nst = 3;
            default: ;
        endcase
        if (m_state != 0 && drop) nst = 0;
        m_exp.mis = e && m_valid && (lm != MF - 1);
        if (e) begin
            m_last_edge = c;
            m_valid     = 1'b1;
        end
        m_state   = nst;
        m_exp.st  = 2'(nst);
        m_exp.vld = m_valid;
        m_exp.rdy = (nst == 3);
        case (nst)
            2: {m_exp.data, m_exp.k} = ilas_exp(c + 1 - m_ilas_start);
            3: begin
                m_exp.data = din_h[c];
                m_exp.k    = 4'h0;
            end
            default: begin
                m_exp.data = 32'hBCBCBCBC;
                m_exp.k    = 4'hF;
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Called at a falling edge: compare this cycle's outputs, drive next inputs, advance one clock.
    task automatic cycle_step(input logic sr, input logic sn, input logic [31:0] d);
        obs_t got;
        got = {tx_data, tx_charisk, link_state, data_ready, lmfc_valid, sysref_misalign};
        checks++;
        if (got !== m_exp) begin
            errors++;
            $display("FAIL model cyc=%0d got data=%h k=%h st=%0d rdy=%0d vld=%0d mis=%0d exp data=%h k=%h st=%0d rdy=%0d vld=%0d mis=%0d",
                     cyc, got.data, got.k, got.st, got.rdy, got.vld, got.mis,
                     m_exp.data, m_exp.k, m_exp.st, m_exp.rdy, m_exp.vld, m_exp.mis);
        end
        if (cyc >= HMAX - 1) begin
            errors++;
            $display("FAIL history_overflow cyc=%0d limit=%0d", cyc, HMAX - 1);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "history overflow");
        end
        sysref  = sr;
        sync_n  = sn;
        data_in = d;
        sr_h[cyc]  = sr;
        sn_h[cyc]  = sn;
        din_h[cyc] = d;
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit rand_cfg, input bit mid_op);
        reset   = 1'b1;
        sysref  = 1'b0;
        sync_n  = 1'b0;
        data_in = '0;
        if (mid_op) begin
            #1;
            chk("async_reset_state", 32'(link_state), 32'd0);
            chk("async_reset_data", tx_data, 32'd0);
        end
        for (int i = 0; i < 14; i++) begin
            cfg_b[i] = rand_cfg ? 8'($urandom) : 8'(8'hA0 + i);
            cfg_octets[8*i +: 8] = cfg_b[i];
        end
        repeat (3) @(negedge clk);
        reset        = 1'b0;
        cyc          = 0;
        m_state      = 0;
        m_ilas_start = 0;
        m_last_edge  = -1;
        m_valid      = 1'b0;
        m_exp        = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        ilas_vec_t   ilas_tab[10];
        logic [35:0] cap[32];
        int          ilas_cyc;
        int          e_cyc;
        int          not_ilas;
        bit          seen_wait;
        bit          found;
        bit          stayed;
        bit          prev_sr;
        int          drop_left;
        logic        sr;
        logic        sn;

        ilas_tab[0] = '{0,  32'h0302011C, 4'h1};
        ilas_tab[1] = '{1,  32'h07060504, 4'h0};
        ilas_tab[2] = '{7,  32'h7C1E1D1C, 4'h8};
        ilas_tab[3] = '{8,  32'hA1A09C1C, 4'h3};
        ilas_tab[4] = '{9,  32'hA5A4A3A2, 4'h0};
        ilas_tab[5] = '{11, 32'hADACABAA, 4'h0};
        ilas_tab[6] = '{12, 32'h13121110, 4'h0};
        ilas_tab[7] = '{15, 32'h7C1E1D1C, 4'h8};
        ilas_tab[8] = '{16, 32'h0302011C, 4'h1};
        ilas_tab[9] = '{31, 32'h7C1E1D1C, 4'h8};

        @(negedge clk);
        do_reset(1'b0, 1'b0);
        chk("reset_state", 32'(link_state), 32'd0);
        chk("reset_data", tx_data, 32'd0);
        chk("reset_lmfc_valid", 32'(lmfc_valid), 32'd0);

        // CGS with one SYSREF pulse at cycle 2
        cycle_step(1'b0, 1'b0, '0);
        cycle_step(1'b0, 1'b0, '0);
        cycle_step(1'b1, 1'b0, '0);
        repeat (3) cycle_step(1'b0, 1'b0, '0);
        chk("cgs_data", tx_data, 32'hBCBCBCBC);
        chk("cgs_charisk", 32'(tx_charisk), 32'hF);
        chk("cgs_lmfc_valid", 32'(lmfc_valid), 32'd1);
        chk("cgs_state", 32'(link_state), 32'd0);

        // release SYNC~ and wait for ILAS
        seen_wait = 1'b0;
        found     = 1'b0;
        ilas_cyc  = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (link_state == 2'd1) seen_wait = 1'b1;
            if (link_state == 2'd2) begin
                found    = 1'b1;
                ilas_cyc = cyc;
            end else begin
                cycle_step(1'b0, 1'b1, '0);
            end
        end
        chk("wait_lmfc_seen", 32'(seen_wait), 32'd1);
        chk("ilas_reached", 32'(found), 32'd1);
        chk("ilas_lmfc_phase", 32'((ilas_cyc - 3) % MF), 32'd0);

        not_ilas = 0;
        for (int w = 0; w < 32; w++) begin
            cap[w] = {tx_data, tx_charisk};
            if (link_state != 2'd2) not_ilas++;
            cycle_step(1'b0, 1'b1, $urandom);
        end
        chk("ilas_length", 32'(not_ilas), 32'd0);
        chk("data_state", 32'(link_state), 32'd3);
        chk("data_ready", 32'(data_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("ilas_word%0d_data", ilas_tab[i].off), cap[ilas_tab[i].off][35:4], ilas_tab[i].data);
            chk($sformatf("ilas_word%0d_k", ilas_tab[i].off), 32'(cap[ilas_tab[i].off][3:0]), 32'(ilas_tab[i].k));
        end

        // pass-through data, one clock latency
        cycle_step(1'b0, 1'b1, 32'h12345678);
        chk("data_pass", tx_data, 32'h12345678);
        chk("data_charisk", 32'(tx_charisk), 32'd0);
        cycle_step(1'b0, 1'b1, 32'hCAFEF00D);
        chk("data_pass2", tx_data, 32'hCAFEF00D);

        // one-clock SYNC~ glitch is ignored
        stayed = 1'b1;
        cycle_step(1'b0, 1'b0, $urandom);
        for (int i = 0; i < 5; i++) begin
            if (link_state != 2'd3) stayed = 1'b0;
            cycle_step(1'b0, 1'b1, $urandom);
        end
        chk("glitch_ignored", 32'(stayed), 32'd1);

        // four-clock drop returns to CGS
        repeat (4) cycle_step(1'b0, 1'b0, $urandom);
        chk("drop_state", 32'(link_state), 32'd0);
        chk("drop_data", tx_data, 32'hBCBCBCBC);
        chk("drop_ready", 32'(data_ready), 32'd0);

        // re-sync, then SYSREF edge at LMFC phase 3 while in DATA
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (link_state == 2'd3) found = 1'b1;
            else cycle_step(1'b0, 1'b1, $urandom);
        end
        chk("resync_data", 32'(found), 32'd1);
        for (int i = 0; i < MF && lmfc_at(cyc) != 3; i++) cycle_step(1'b0, 1'b1, $urandom);
        e_cyc = cyc;
        cycle_step(1'b1, 1'b1, $urandom);
        chk("misalign_pulse", 32'(sysref_misalign), 32'd1);
        chk("misalign_state", 32'(link_state), 32'd3);
        cycle_step(1'b0, 1'b1, $urandom);
        chk("misalign_one_clk", 32'(sysref_misalign), 32'd0);
        while (cyc < e_cyc + 8) cycle_step(1'b0, 1'b1, $urandom);
        cycle_step(1'b1, 1'b1, $urandom);
        chk("realigned_edge", 32'(sysref_misalign), 32'd0);
        cycle_step(1'b0, 1'b1, $urandom);

        // randomized traffic, each segment entered by a mid-operation reset
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(1'b1, 1'b1);
            prev_sr   = 1'b0;
            drop_left = 0;
            for (int i = 0; i < 1200; i++) begin
                sr = ($urandom_range(0, 199) == 0) ||
                     (lmfc_at(cyc) == MF - 1 && $urandom_range(0, 39) == 0) ||
                     (prev_sr && $urandom_range(0, 1) == 0) || (i == 5);
                if (i < 15) begin
                    sn = 1'b0;
                end else if (drop_left > 0) begin
                    sn = 1'b0;
                    drop_left--;
                end else if ($urandom_range(0, 149) == 0) begin
                    sn = 1'b0;
                    drop_left = $urandom_range(0, 4);
                end else begin
                    sn = 1'b1;
                end
                prev_sr = sr;
                cycle_step(sr, sn, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
